// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind a UART receiver: sync / length / payload / checksum
// parsing into a small buffer that the consumer drains and then releases.
module uart_rx_frame_ctrl #(
   parameter logic [7:0] SYNC_BYTE     = 8'hA5,
   parameter int         MAX_LEN       = 16,
   parameter int         TIMEOUT_TICKS = 320
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_done,
   input  logic [7:0] rx_data,
   input  logic       s_tick,
   input  logic       rd_en,
   input  logic       frame_ack,
   output logic [7:0] rd_data,
   output logic       rd_empty,
   output logic       frame_valid,
   output logic [4:0] frame_len,
   output logic       err_checksum,
   output logic       err_length,
   output logic       err_timeout,
   output logic       err_overrun,
   output logic       busy
);

   localparam int            TW        = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_TICKS - 1);
   localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CSUM, DONE} state_t;

   state_t        state, state_nxt;
   logic          rx_done_q;
   logic          armed;
   logic          byte_ev;
   logic [4:0]    len_q;
   logic [4:0]    wr_ptr;
   logic [4:0]    rd_ptr;
   logic [7:0]    sum;
   logic [7:0]    sum_plus;
   logic [TW-1:0] tout_cnt;
   logic          tout_hit;
   logic          len_ok;
   logic          set_checksum, set_length, set_timeout, set_overrun;
   logic [7:0]    buffer [0:31];

   // armed masks the first cycle after reset so a level already high is not an edge
   assign byte_ev  = rx_done & ~rx_done_q & armed;
   assign sum_plus = sum + rx_data;
   assign len_ok   = (rx_data != 8'd0) && (rx_data <= MAX_LEN_B);
   assign tout_hit = s_tick && (tout_cnt == TOUT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every comb output gets a default first, otherwise a missed branch infers a latch.
   always_comb begin
      state_nxt    = state;
      set_checksum = 1'b0;
      set_length   = 1'b0;
      set_timeout  = 1'b0;
      set_overrun  = 1'b0;
      case (state)
         IDLE: begin
            if (byte_ev && rx_data == SYNC_BYTE) state_nxt = LEN;
         end
         LEN: begin
            if (byte_ev) begin
               if (len_ok) begin
                  state_nxt = PAYLOAD;
               end else begin
                  set_length = 1'b1;
                  state_nxt  = IDLE;
               end
            end else if (tout_hit) begin
               set_timeout = 1'b1;
               state_nxt   = IDLE;
            end
         end
         PAYLOAD: begin
            if (byte_ev) begin
               if (wr_ptr + 5'd1 == len_q) state_nxt = CSUM;
            end else if (tout_hit) begin
               set_timeout = 1'b1;
               state_nxt   = IDLE;
            end
         end
         CSUM: begin
            if (byte_ev) begin
               if (sum_plus == 8'd0) begin
                  state_nxt = DONE;
               end else begin
                  set_checksum = 1'b1;
                  state_nxt    = IDLE;
               end
            end else if (tout_hit) begin
               set_timeout = 1'b1;
               state_nxt   = IDLE;
            end
         end
         DONE: begin
            if (byte_ev)   set_overrun = 1'b1;
            if (frame_ack) state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_done_q    <= 1'b0;
         armed        <= 1'b0;
         len_q        <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         sum          <= '0;
         tout_cnt     <= '0;
         err_checksum <= 1'b0;
         err_length   <= 1'b0;
         err_timeout  <= 1'b0;
         err_overrun  <= 1'b0;
      end else begin
         rx_done_q    <= rx_done;
         armed        <= 1'b1;
         err_checksum <= set_checksum;
         err_length   <= set_length;
         err_timeout  <= set_timeout;
         err_overrun  <= set_overrun;

         if (byte_ev || state == IDLE || state == DONE || state_nxt == IDLE) begin
            tout_cnt <= '0;
         end else if (s_tick) begin
            tout_cnt <= tout_cnt + TW'(1);
         end

         case (state)
            IDLE: begin
               if (byte_ev && rx_data == SYNC_BYTE) begin
                  sum    <= '0;
                  wr_ptr <= '0;
                  rd_ptr <= '0;
               end
            end
            LEN: begin
               if (byte_ev && len_ok) begin
                  len_q <= rx_data[4:0];
                  sum   <= rx_data;
               end
            end
            PAYLOAD: begin
               if (byte_ev) begin
                  wr_ptr <= wr_ptr + 5'd1;
                  sum    <= sum_plus;
               end
            end
            DONE: begin
               // release wins over a simultaneous pop
               if (frame_ack) begin
                  rd_ptr <= '0;
               end else if (rd_en && !rd_empty) begin
                  rd_ptr <= rd_ptr + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: the payload buffer is plain storage and is deliberately not reset; reads are gated by rd_empty.
   always_ff @(posedge clk) begin
      if (state == PAYLOAD && byte_ev) buffer[wr_ptr] <= rx_data;
   end

   always_comb begin
      busy        = (state != IDLE);
      frame_valid = (state == DONE);
      frame_len   = (state == DONE) ? len_q : 5'd0;
      rd_empty    = !((state == DONE) && (rd_ptr < len_q));
      rd_data     = rd_empty ? 8'd0 : buffer[rd_ptr];
   end

endmodule

// File: doc/uart_rx_frame_ctrl.md
UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum payload bytes (1..31).
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 320, s_tick count allowed between bytes (20 bit times).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port rx_done  input  1  receiver byte-complete level; may stay high for many cycles.
REQ-007 SHALL have port rx_data  input  8  received byte; valid while rx_done=1.
REQ-008 SHALL have port s_tick  input  1  16x-oversample baud tick, one cycle wide.
REQ-009 SHALL have port rd_en  input  1  pop one payload byte.
REQ-010 SHALL have port frame_ack  input  1  consumer releases the frame buffer.
REQ-011 SHALL have port rd_data  output  8  payload byte at read pointer (show-ahead).
REQ-012 SHALL have port rd_empty  output  1  no unread payload byte available.
REQ-013 SHALL have port frame_valid  output  1  complete, checksum-good frame held.
REQ-014 SHALL have port frame_len  output  5  payload length of held frame.
REQ-015 SHALL have port err_checksum, err_length, err_timeout, err_overrun  output  1 each  one-cycle error pulses.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL define a byte event as the rising edge of rx_done (registered previous value); a level held high SHALL count once.
REQ-018 SHALL implement states IDLE, LEN, PAYLOAD, CSUM, DONE.
REQ-019 IDLE: byte event with rx_data==SYNC_BYTE -> LEN, clear sum and counters; any other byte ignored.
REQ-020 LEN: byte event with 1<=rx_data<=MAX_LEN -> store len, sum=rx_data, -> PAYLOAD; otherwise pulse err_length, -> IDLE.
REQ-021 PAYLOAD: each byte event writes buffer[wr_ptr], wr_ptr+1, sum+=rx_data mod 256; after len-th byte -> CSUM.
REQ-022 CSUM: byte event with (sum+rx_data) mod 256 == 0 -> DONE, frame_valid=1, frame_len=len; else pulse err_checksum, -> IDLE.
REQ-023 Timeout counter SHALL clear on each byte event and on entering LEN, increment on s_tick in LEN/PAYLOAD/CSUM; on reaching TIMEOUT_TICKS pulse err_timeout, -> IDLE.
REQ-024 Byte event and timeout expiry in the same cycle: byte event wins, counter clears.
REQ-025 DONE: rd_data=buffer[rd_ptr] combinationally; rd_en with rd_empty=0 advances rd_ptr next cycle; rd_en with rd_empty=1 ignored.
REQ-026 rd_empty SHALL be 1 unless state==DONE and rd_ptr<frame_len.
REQ-027 DONE: byte event SHALL be dropped and pulse err_overrun; buffer unchanged.
REQ-028 frame_ack in DONE -> IDLE next cycle, frame_valid=0, rd_ptr=0; frame_ack outside DONE ignored; frame_ack with rd_en same cycle: ack wins, no pop.
REQ-029 Error pulses SHALL be exactly one clk cycle, registered, asserted the cycle after the causing event.
REQ-030 Sum SHALL be 8 bit wrap-around; len/pointers 5 bit; timeout counter ceil(log2(TIMEOUT_TICKS+1)) bits.

Reset
REQ-031 reset=0 SHALL immediately force state IDLE, pointers, sum, timeout counter, rx_done history to 0.
REQ-032 Reset values: rd_data=0, rd_empty=1, frame_valid=0, frame_len=0, all err_*=0, busy=0.
REQ-033 rx_done already high when reset releases SHALL NOT produce a byte event.
REQ-034 Reset mid-frame SHALL discard the partial frame; next SYNC_BYTE starts a fresh frame.

Verification
REQ-035 Bytes A5 03 11 22 33 97 -> frame_valid=1, frame_len=3, rd_data 11,22,33 on successive rd_en, then rd_empty=1; frame_ack -> busy=0.
REQ-036 Bytes A5 03 11 22 33 98 -> single err_checksum pulse, frame_valid stays 0, state IDLE.
REQ-037 A5 00 and A5 11 (17) -> err_length pulse each, IDLE; preceding bytes 00 FF 5A before A5 ignored, busy stays 0.
REQ-038 A5 02 11 then no byte for 320 s_ticks -> err_timeout on tick 320; byte arriving on tick 320 instead continues frame.
REQ-039 rx_done held high 50 cycles per byte -> each byte counted once; extra byte in DONE -> err_overrun, data still 11,22,33.
REQ-040 reset pulsed low after A5 03 11 -> all outputs at reset values within same cycle; following valid frame accepted.
